// File: rtl/mul_real_arb_pkg.sv
// Shared types and helpers for the round-robin multiplier arbiter.
// Tags are sized for the largest supported requester count (8).
package mul_real_arb_pkg;

  localparam int N_REQ_MAX = 8;

  typedef logic [$clog2(N_REQ_MAX)-1:0] tag_t;

  // Right-shift amount that moves a product at exponent (exp_a+exp_b) to exp_o;
  // a negative value means a left shift.
  function automatic int align_shift(input int exp_a, input int exp_b, input int exp_o);
    return exp_o - (exp_a + exp_b);
  endfunction

endpackage

// File: rtl/mul_real_arbiter_if.sv
// Requester-side bus of the shared multiplier: issue handshake, per-requester
// result handshake and busy flags, packed WIDTH bits per requester.
interface mul_real_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 18
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       resp_valid;
  logic [N_REQ-1:0]       resp_ready;
  logic [N_REQ*WIDTH-1:0] resp_data;
  logic [N_REQ-1:0]       busy;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/mul_real_pipe.sv
// Signed fixed-point multiply with exponent alignment; an input register stage
// followed by PIPE register stages, carrying valid and tag alongside the data.
module mul_real_pipe
  import mul_real_arb_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int EXP_A = -8,
  parameter int EXP_B = -8,
  parameter int EXP_O = -8,
  parameter int PIPE  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  tag_t                    i_tag,
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic                    o_valid,
  output tag_t                    o_tag,
  output logic signed [WIDTH-1:0] o_data
);

  localparam int SHIFT = align_shift(EXP_A, EXP_B, EXP_O);

  typedef struct packed {
    logic             valid;
    tag_t             tag;
    logic [WIDTH-1:0] data;
  } stage_t;

  logic                      r_s0_valid;
  tag_t                      r_s0_tag;
  logic signed [WIDTH-1:0]   r_s0_a;
  logic signed [WIDTH-1:0]   r_s0_b;
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [WIDTH-1:0]   w_aligned;
  stage_t                    w_head;
  stage_t                    w_tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s0_tag   <= '0;
      r_s0_a     <= '0;
      r_s0_b     <= '0;
    end else begin
      r_s0_valid <= i_valid;
      r_s0_tag   <= i_tag;
      r_s0_a     <= i_a;
      r_s0_b     <= i_b;
    end
  end

  assign w_prod = (2*WIDTH)'(r_s0_a) * (2*WIDTH)'(r_s0_b);

  // Keep only the low WIDTH bits after alignment: wraps like MUL_REAL, no saturation.
  generate
    if (SHIFT >= 0) begin : g_shr
      assign w_aligned = WIDTH'(w_prod >>> SHIFT);
    end else begin : g_shl
      assign w_aligned = WIDTH'(w_prod <<< (-SHIFT));
    end
  endgenerate

  assign w_head = '{valid: r_s0_valid, tag: r_s0_tag, data: w_aligned};

  generate
    if (PIPE == 0) begin : g_nopipe
      assign w_tail = w_head;
    end else begin : g_pipe
      stage_t r_stage [PIPE];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < PIPE; k++) r_stage[k] <= '0;
        end else begin
          r_stage[0] <= w_head;
          for (int k = 1; k < PIPE; k++) r_stage[k] <= r_stage[k-1];
        end
      end

      assign w_tail = r_stage[PIPE-1];
    end
  endgenerate

  assign o_valid = w_tail.valid;
  assign o_tag   = w_tail.tag;
  assign o_data  = w_tail.data;

endmodule

// File: rtl/mul_real_arbiter.sv
// Round-robin front end sharing one pipelined fixed-point multiplier among
// N_REQ requesters, each with one op in flight and a held result register.
module mul_real_arbiter
  import mul_real_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 18,
  parameter int EXP_A = -8,
  parameter int EXP_B = -8,
  parameter int EXP_O = -8,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  mul_real_arbiter_if.slave bus
);

  logic [N_REQ-1:0]        r_busy;
  logic [N_REQ-1:0]        r_resp_valid;
  logic signed [WIDTH-1:0] r_resp_data [N_REQ];
  tag_t                    r_ptr;

  logic [N_REQ-1:0]        w_elig;
  logic [N_REQ-1:0]        w_grant;
  logic                    w_any;
  tag_t                    w_win;
  logic signed [WIDTH-1:0] w_iss_a;
  logic signed [WIDTH-1:0] w_iss_b;
  logic                    w_out_valid;
  tag_t                    w_out_tag;
  logic signed [WIDTH-1:0] w_out_data;

  // busy covers both in-flight and unconsumed results, so tags never collide.
  assign w_elig = bus.req_valid & ~r_busy;

  // Scan offsets from the pointer; the first eligible requester wins.
  always_comb begin
    w_grant = '0;
    w_win   = '0;
    w_any   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_any && w_elig[i] && ((int'(r_ptr) + k) % N_REQ == i)) begin
          w_any      = 1'b1;
          w_grant[i] = 1'b1;
          w_win      = tag_t'(i);
        end
      end
    end
  end

  always_comb begin
    w_iss_a = '0;
    w_iss_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_iss_a = bus.req_a[i*WIDTH +: WIDTH];
        w_iss_b = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  mul_real_pipe #(
    .WIDTH(WIDTH),
    .EXP_A(EXP_A),
    .EXP_B(EXP_B),
    .EXP_O(EXP_O),
    .PIPE (PIPE)
  ) u_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_valid(w_any),
    .i_tag  (w_win),
    .i_a    (w_iss_a),
    .i_b    (w_iss_b),
    .o_valid(w_out_valid),
    .o_tag  (w_out_tag),
    .o_data (w_out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_busy       <= '0;
      r_resp_valid <= '0;
      for (int i = 0; i < N_REQ; i++) r_resp_data[i] <= '0;
    end else begin
      if (w_any) begin
        r_ptr <= (int'(w_win) == N_REQ - 1) ? '0 : tag_t'(w_win + 1'b1);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (w_grant[i]) begin
          r_busy[i] <= 1'b1;
        end else if (r_resp_valid[i] && bus.resp_ready[i]) begin
          r_busy[i] <= 1'b0;
        end
        if (w_out_valid && w_out_tag == tag_t'(i)) begin
          r_resp_valid[i] <= 1'b1;
          r_resp_data[i]  <= w_out_data;
        end else if (bus.resp_ready[i]) begin
          r_resp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready  = rst ? '0 : w_grant;
  assign bus.resp_valid = r_resp_valid;
  assign bus.busy       = r_busy;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_resp
      assign bus.resp_data[gi*WIDTH +: WIDTH] = r_resp_data[gi];
    end
  endgenerate

endmodule

// File: tb/tb_mul_real_arbiter.sv
// Directed bench for mul_real_arbiter: per-cycle comparison against a queue-based
// model of the arbiter, plus hand-computed literal expectations.
module tb_mul_real_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int EA = -8;
  localparam int EB = -8;
  localparam int EO = -8;
  localparam int P  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_real_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
  mul_real_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus2 ();

  mul_real_arbiter #(.N_REQ(N), .WIDTH(W), .EXP_A(EA), .EXP_B(EB), .EXP_O(EO), .PIPE(P))
    dut (.clk(clk), .rst(rst), .bus(bus));

  mul_real_arbiter #(.N_REQ(N), .WIDTH(W), .EXP_A(-8), .EXP_B(-9), .EXP_O(-10), .PIPE(P))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int                  tag;
    logic signed [W-1:0] data;
    int                  remain;
  } fl_t;

  fl_t                 fl[$];
  bit                  m_busy [N];
  bit                  m_rv   [N];
  logic signed [W-1:0] m_data [N];
  int                  m_ptr;
  bit                  armed = 1'b0;
  logic [N-1:0]        mg;
  logic [N-1:0]        eg, eb, erv;
  logic [N*W-1:0]      ed;

  function automatic logic signed [W-1:0] model_mul(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b,
                                                    input int ea, input int eb_, input int eo);
    longint p;
    int     s;
    p = longint'(a) * longint'(b);
    s = eo - (ea + eb_);
    if (s >= 0) p = p >>> s;
    else        p = p <<< (-s);
    return p[W-1:0];
  endfunction

  function automatic logic [N-1:0] model_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (bus.req_valid[idx] && !m_busy[idx]) return (N)'(1) << idx;
    end
    return '0;
  endfunction

  function automatic logic signed [W-1:0] opa(input int i);
    return bus.req_a[i*W +: W];
  endfunction

  function automatic logic signed [W-1:0] opb(input int i);
    return bus.req_b[i*W +: W];
  endfunction

  function automatic logic signed [W-1:0] rdata(input int i);
    return bus.resp_data[i*W +: W];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      fl.delete();
      m_ptr = 0;
      for (int i = 0; i < N; i++) begin
        m_busy[i] = 1'b0;
        m_rv[i]   = 1'b0;
        m_data[i] = '0;
      end
      armed = 1'b1;
    end else if (armed) begin
      fl_t e;
      mg = model_grant();
      for (int i = 0; i < N; i++) begin
        if (bus.resp_ready[i] && m_rv[i]) begin
          m_rv[i]   = 1'b0;
          m_busy[i] = 1'b0;
        end
      end
      for (int j = fl.size() - 1; j >= 0; j--) begin
        fl[j].remain = fl[j].remain - 1;
        if (fl[j].remain == 0) begin
          m_rv[fl[j].tag]   = 1'b1;
          m_data[fl[j].tag] = fl[j].data;
          fl.delete(j);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (mg[i]) begin
          e.tag    = i;
          e.data   = model_mul(opa(i), opb(i), EA, EB, EO);
          e.remain = P + 1;
          fl.push_back(e);
          m_busy[i] = 1'b1;
          m_ptr     = (i + 1) % N;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      eg = rst ? '0 : model_grant();
      for (int i = 0; i < N; i++) begin
        eb[i]          = m_busy[i];
        erv[i]         = m_rv[i];
        ed[i*W +: W]   = m_data[i];
      end
      chk("req_ready", bus.req_ready, eg);
      chk("busy", bus.busy, eb);
      chk("resp_valid", bus.resp_valid, erv);
      chk("resp_data", bus.resp_data, ed);
    end
  end

  // ---------------- stimulus ----------------
  int gcnt [N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  initial begin
    bus.req_valid   = '0;
    bus.req_a       = '0;
    bus.req_b       = '0;
    bus.resp_ready  = '0;
    bus2.req_valid  = '0;
    bus2.req_a      = '0;
    bus2.req_b      = '0;
    bus2.resp_ready = '0;
    rst = 1'b1;
    repeat (3) tick();

    // Pin the model with hand-computed results.
    chk("model_1p5x-2", model_mul(16'sd384, -16'sd512, -8, -8, -8), -768);
    chk("model_wrap", model_mul(16'sd32767, 16'sd32767, -8, -8, -8), -256);
    chk("model_align", model_mul(16'sd256, -16'sd3, -8, -9, -10), -6);
    chk("model_floor", model_mul(16'sd1, -16'sd3, -8, -9, -10), -1);

    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_req_ready", bus.req_ready, 0);

    // Single op: 1.5 * -2.0 = -3.0, result three edges after the grant.
    tick();
    set_op(0, 16'sd384, -16'sd512);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_grant", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    chk("t1_busy", bus.busy[0], 1);
    chk("t1_rv_T", bus.resp_valid[0], 0);
    tick();
    chk("t1_rv_T1", bus.resp_valid[0], 0);
    tick();
    chk("t1_rv_T2", bus.resp_valid[0], 0);
    tick();
    chk("t1_rv_T3", bus.resp_valid[0], 1);
    chk("t1_data", rdata(0), -768);
    repeat (2) begin
      tick();
      chk("t1_hold_rv", bus.resp_valid[0], 1);
      chk("t1_hold_data", rdata(0), -768);
      chk("t1_hold_busy", bus.busy[0], 1);
    end
    bus.resp_ready = 4'b0001;
    tick();
    bus.resp_ready = '0;
    chk("t1_consumed_rv", bus.resp_valid[0], 0);
    chk("t1_consumed_busy", bus.busy[0], 0);

    // Round robin from a fresh pointer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 16'(256 * (i + 1)), 16'sd256);
    bus.req_valid  = 4'b1111;
    bus.resp_ready = 4'b1111;
    begin
      logic [N-1:0] gseq [6];
      logic [N-1:0] rseq [6];
      gseq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001};
      rseq = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100};
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        chk("t2_grant", bus.req_ready, gseq[c]);
        tick();
        chk("t2_resp_order", bus.resp_valid, rseq[c]);
      end
    end
    chk("t2_data2", rdata(2), 768);
    bus.req_valid = '0;
    repeat (8) tick();

    // Back-pressure on requester 1: 2.5 * -1.0 = -2.5.
    set_op(1, 16'sd640, -16'sd256);
    bus.resp_ready = 4'b1101;
    bus.req_valid  = 4'b1111;
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) gcnt[i]++;
      if (bus.resp_valid[1]) chk("t3_hold_data", rdata(1), -640);
      tick();
    end
    chk("t3_rv1_held", bus.resp_valid[1], 1);
    chk("t3_grants1", gcnt[1], 1);
    chk("t3_served0", gcnt[0] >= 3, 1);
    chk("t3_served2", gcnt[2] >= 3, 1);
    chk("t3_served3", gcnt[3] >= 3, 1);
    bus.req_valid  = '0;
    bus.resp_ready = 4'b1111;
    repeat (8) tick();

    // Wrap: 32767*32767 >>> 8 = 0x3FFF00, low 16 bits = -256.
    bus.resp_ready = '0;
    set_op(2, 16'sd32767, 16'sd32767);
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
    chk("t5_rv", bus.resp_valid[2], 1);
    chk("t5_data", rdata(2), -256);
    bus.resp_ready = 4'b0100;
    tick();
    bus.resp_ready = '0;

    // Reset with two ops in flight.
    set_op(0, 16'sd100, 16'sd200);
    set_op(3, -16'sd50, 16'sd300);
    bus.req_valid  = 4'b1001;
    bus.resp_ready = 4'b1111;
    tick();
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", bus.busy, 0);
    chk("t6_resp_valid", bus.resp_valid, 0);
    chk("t6_resp_data", bus.resp_data, 0);
    chk("t6_req_ready", bus.req_ready, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t6_no_ghost", bus.resp_valid, 0);
    end
    bus.resp_ready = '0;
    set_op(1, -16'sd384, 16'sd512);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
    chk("t6_after_rv", bus.resp_valid, 4'b0010);
    chk("t6_after_data", rdata(1), -768);
    bus.resp_ready = 4'b0010;
    tick();
    bus.resp_ready = '0;

    // Alignment: s = -10 - (-17) = 7.  256*-3 = -768 >>> 7 = -6; 1*-3 >>> 7 = -1.
    bus2.req_a[0 +: W] = 16'sd256;
    bus2.req_b[0 +: W] = -16'sd3;
    bus2.req_valid = 4'b0001;
    tick();
    bus2.req_valid = '0;
    repeat (3) tick();
    chk("t4_rv", bus2.resp_valid[0], 1);
    chk("t4_data", $signed(bus2.resp_data[0 +: W]), -6);
    bus2.resp_ready = 4'b0001;
    tick();
    bus2.resp_ready = '0;
    bus2.req_a[0 +: W] = 16'sd1;
    bus2.req_b[0 +: W] = -16'sd3;
    bus2.req_valid = 4'b0001;
    tick();
    bus2.req_valid = '0;
    repeat (3) tick();
    chk("t4_floor_rv", bus2.resp_valid[0], 1);
    chk("t4_floor_data", $signed(bus2.resp_data[0 +: W]), -1);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
